// File: rtl/dec_timer_pkg.sv
// dec_timer_pkg: shared types and default sizing for the down-counting timer.
package dec_timer_pkg;

  // Timer control states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 4;

endpackage

// File: rtl/dec_timer_prescaler.sv
// dec_timer_prescaler: counts 0..DIV-1 on the system clock and flags the
// terminal cycle as a decrement tick. clear wins over everything, hold freezes
// a partially elapsed prescale so a paused timer can resume where it left off.
module dec_timer_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic hold,
  output logic tick
);

  localparam int PW = $clog2(DIV) + 1;
  localparam logic [PW-1:0] PS_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PS_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PS_TERM = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_term_s;
  logic          adv_s;

  assign at_term_s = (cnt_q == PS_TERM);
  assign adv_s     = enable & ~hold & ~clear;
  assign tick      = adv_s & at_term_s;

  // Next prescale count: clear, advance with wrap, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = PS_ZERO;
    end else if (adv_s) begin
      if (at_term_s) begin
        cnt_d = PS_ZERO;
      end else begin
        cnt_d = cnt_q + PS_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= PS_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec_timer.sv
// dec_timer: loadable down-counting timer. The host loads a start value,
// starts it, and the count drops once per prescaled tick until it expires.
// Optional feature macro: DEC_TIMER_AUTORELOAD_EN -- when defined, expiry in
// RUN reloads the last written value and keeps running instead of entering DONE.
// Note: start from IDLE does not clear the prescaler; it is already zero after
// a load, and after a stop it keeps the partial prescale so a resume continues.
module dec_timer
  import dec_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_en,
  input  logic [WIDTH-1:0] datain,
  input  logic             start,
  input  logic             stop,
  input  logic             dec,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             zero,
  output logic             expired
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             busy_q;
  logic             zero_q;
  logic             expired_q;
  logic             expired_d;
  logic             run_s;
  logic             tick_s;

  // Manual decrement never wraps below zero.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == CNT_ZERO) begin
      r = CNT_ZERO;
    end else begin
      r = v - CNT_ONE;
    end
    return r;
  endfunction

  assign run_s = (state_q == ST_RUN);

  dec_timer_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (write_en),
    .enable  (run_s),
    .hold    (stop),
    .tick    (tick_s)
  );

`ifdef DEC_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;

  // Reload value follows every host write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= CNT_ZERO;
    end else if (write_en) begin
      reload_q <= datain;
    end else begin
      reload_q <= reload_q;
    end
  end
`endif

  // Next state, next count and expiry pulse, priority write > stop > start > dec > tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (write_en) begin
      count_d = datain;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            if (count_q != CNT_ZERO) begin
              state_d = ST_RUN;
            end else begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end
          end else if (dec) begin
            count_d = sat_dec(count_q);
          end else begin
            count_d = count_q;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (tick_s) begin
            if (count_q == CNT_ONE) begin
              expired_d = 1'b1;
`ifdef DEC_TIMER_AUTORELOAD_EN
              if (reload_q != CNT_ZERO) begin
                count_d = reload_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = ST_DONE;
              end
`else
              count_d = CNT_ZERO;
              state_d = ST_DONE;
`endif
            end else begin
              count_d = sat_dec(count_q);
            end
          end else begin
            count_d = count_q;
          end
        end
        ST_DONE: begin
          count_d = CNT_ZERO;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_ZERO;
      busy_q    <= 1'b0;
      zero_q    <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= (state_d == ST_RUN);
      zero_q    <= (count_d == CNT_ZERO);
      expired_q <= expired_d;
    end
  end

  assign dout    = count_q;
  assign busy    = busy_q;
  assign zero    = zero_q;
  assign expired = expired_q;

endmodule
